// File: rtl/rx_deser_if.sv
// Byte-in / word-out bus of rx_deser: UART byte strobe, flush, and the
// valid/ready word handshake plus status pulses.
interface rx_deser_if #(
  parameter int unsigned NBYTES = 16
);
  logic [7:0]                   din;
  logic                         rx_done;
  logic                         flush;
  logic [NBYTES*8-1:0]          dout;
  logic                         dout_valid;
  logic                         dout_ready;
  logic [$clog2(NBYTES+1)-1:0]  byte_cnt;
  logic                         overrun;
  logic                         timeout;

  modport slave (
    input  din, rx_done, flush, dout_ready,
    output dout, dout_valid, byte_cnt, overrun, timeout
  );

  modport master (
    output din, rx_done, flush, dout_ready,
    input  dout, dout_valid, byte_cnt, overrun, timeout
  );
endinterface

// File: rtl/rx_deser.sv
// rx_deser: packs NBYTES UART bytes into one word and offers it on valid/ready.
// Define RX_DESER_TIMEOUT_EN to discard partial words after TIMEOUT_CYC idle cycles.
module rx_deser #(
  parameter int unsigned NBYTES      = 16,
  parameter bit          MSB_FIRST   = 1'b1,
  parameter int unsigned TIMEOUT_CYC = 1_000_000
) (
  input  logic      clk,
  input  logic      reset,
  rx_deser_if.slave bus
);

  localparam int unsigned   W         = NBYTES * 8;
  localparam int unsigned   CW        = $clog2(NBYTES + 1);
  localparam logic [CW-1:0] LAST_SLOT = CW'(NBYTES - 1);

  if (NBYTES < 2) begin : g_bad_nbytes
    $error("rx_deser: NBYTES must be at least 2");
  end
  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("rx_deser: TIMEOUT_CYC must be at least 1");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_HOLD
  } state_e;

  state_e        state_q, state_d;
  logic [W-1:0]  buf_q, buf_d;
  logic [W-1:0]  dout_q, dout_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          overrun_q, overrun_d;
  logic          timeout_d;

`ifdef RX_DESER_TIMEOUT_EN
  localparam int unsigned   TW         = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYC - 1);

  logic [TW-1:0] timer_q, timer_d;
  logic          timeout_q;
`endif

  // Returns w with byte b written into slot `slot`, honouring the byte order.
  function automatic logic [W-1:0] place(input logic [W-1:0]  w,
                                         input logic [CW-1:0] slot,
                                         input logic [7:0]    b);
    logic [W-1:0] r;
    r = w;
    for (int k = 0; k < int'(NBYTES); k++) begin
      if (slot == CW'(k)) begin
        if (MSB_FIRST) r[(int'(NBYTES) - 1 - k) * 8 +: 8] = b;
        else           r[k * 8 +: 8] = b;
      end
    end
    return r;
  endfunction

  // NOTE: every output of this block gets a default before any branch, so no
  // path leaves a variable unassigned and no latch can be inferred.
  always_comb begin
    state_d   = state_q;
    buf_d     = buf_q;
    dout_d    = dout_q;
    cnt_d     = cnt_q;
    overrun_d = 1'b0;
    timeout_d = 1'b0;
`ifdef RX_DESER_TIMEOUT_EN
    timer_d   = '0;
`endif

    if (bus.flush) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (bus.rx_done) begin
            buf_d   = place(buf_q, '0, bus.din);
            cnt_d   = CW'(1);
            state_d = S_FILL;
          end
        end

        S_FILL: begin
          if (bus.rx_done) begin
            if (cnt_q == LAST_SLOT) begin
              dout_d  = place(buf_q, cnt_q, bus.din);
              cnt_d   = '0;
              state_d = S_HOLD;
            end else begin
              buf_d = place(buf_q, cnt_q, bus.din);
              cnt_d = cnt_q + CW'(1);
            end
          end
`ifdef RX_DESER_TIMEOUT_EN
          // A strobe in the expiry cycle is handled above and wins.
          else if (timer_q == TIMER_LAST) begin
            state_d   = S_IDLE;
            cnt_d     = '0;
            timeout_d = 1'b1;
          end else begin
            timer_d = timer_q + TW'(1);
          end
`endif
        end

        S_HOLD: begin
          if (bus.dout_ready) begin
            if (bus.rx_done) begin
              buf_d   = place(buf_q, '0, bus.din);
              cnt_d   = CW'(1);
              state_d = S_FILL;
            end else begin
              state_d = S_IDLE;
            end
          end else if (bus.rx_done) begin
            overrun_d = 1'b1;
          end
        end

        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      buf_q     <= '0;
      dout_q    <= '0;
      cnt_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      buf_q     <= buf_d;
      dout_q    <= dout_d;
      cnt_q     <= cnt_d;
      overrun_q <= overrun_d;
    end
  end

`ifdef RX_DESER_TIMEOUT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timer_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      timer_q   <= timer_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.timeout = timeout_q;
`else
  assign bus.timeout = 1'b0;
`endif

  assign bus.dout       = dout_q;
  assign bus.dout_valid = (state_q == S_HOLD);
  assign bus.byte_cnt   = cnt_q;
  assign bus.overrun    = overrun_q;

endmodule

// File: tb/tb_rx_deser.sv
// Directed bench for rx_deser: a 16-byte MSB-first instance and a 4-byte
// LSB-first instance, each driven through its own interface.
module tb_rx_deser;

`ifdef RX_DESER_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  rx_deser_if #(.NBYTES(16)) if16 ();
  rx_deser_if #(.NBYTES(4))  if4 ();

  rx_deser #(.NBYTES(16), .MSB_FIRST(1'b1), .TIMEOUT_CYC(20)) u16 (
    .clk   (clk),
    .reset (reset),
    .bus   (if16)
  );

  rx_deser #(.NBYTES(4), .MSB_FIRST(1'b0), .TIMEOUT_CYC(20)) u4 (
    .clk   (clk),
    .reset (reset),
    .bus   (if4)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe16(input logic [7:0] b);
    if16.rx_done = 1'b1;
    if16.din     = b;
    tick();
    if16.rx_done = 1'b0;
  endtask

  task automatic strobe4(input logic [7:0] b);
    if4.rx_done = 1'b1;
    if4.din     = b;
    tick();
    if4.rx_done = 1'b0;
  endtask

  logic [31:0]  valid_seq;
  logic         ovr_seen;
  logic         to_seen;
  logic [127:0] word_a;
  logic [127:0] word_b;

  initial begin
    reset           = 1'b1;
    if16.din        = '0;
    if16.rx_done    = 1'b0;
    if16.flush      = 1'b0;
    if16.dout_ready = 1'b0;
    if4.din         = '0;
    if4.rx_done     = 1'b0;
    if4.flush       = 1'b0;
    if4.dout_ready  = 1'b0;

    // Reset state
    #1;
    check("rst_dout",     if16.dout,       '0);
    check("rst_valid",    if16.dout_valid, 0);
    check("rst_cnt",      if16.byte_cnt,   0);
    check("rst_overrun",  if16.overrun,    0);
    check("rst_timeout",  if16.timeout,    0);
    check("rst_dout4",    if4.dout,        '0);
    tick();
    tick();
    reset = 1'b0;
    tick();

    // Full 16-byte word, MSB first, gap of 3 idle cycles
    if16.dout_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      strobe16(8'(i));
      if (i == 0) check("t1_cnt_first", if16.byte_cnt, 1);
      if (i == 14) begin
        check("t1_cnt_15",   if16.byte_cnt,   15);
        check("t1_valid_15", if16.dout_valid, 0);
      end
      if (i < 15) repeat (3) tick();
    end
    check("t1_valid", if16.dout_valid, 1);
    check("t1_dout",  if16.dout, 128'h000102030405060708090A0B0C0D0E0F);
    check("t1_cnt_0", if16.byte_cnt, 0);
    tick();
    check("t1_valid_drop", if16.dout_valid, 0);

    // 4-byte word, LSB first, consumer stalled
    strobe4(8'hA1);
    strobe4(8'hB2);
    strobe4(8'hC3);
    strobe4(8'hD4);
    check("t2_valid", if4.dout_valid, 1);
    check("t2_dout",  if4.dout, 32'hD4C3B2A1);
    check("t2_cnt",   if4.byte_cnt, 0);
    tick();
    check("t3_hold_valid", if4.dout_valid, 1);

    // Byte while held and not ready: dropped with overrun pulse
    strobe4(8'h55);
    check("t3_overrun",    if4.overrun,    1);
    check("t3_dout_kept",  if4.dout,       32'hD4C3B2A1);
    check("t3_valid_kept", if4.dout_valid, 1);
    tick();
    check("t3_overrun_1cyc", if4.overrun, 0);

    // Ready together with a strobe: transfer and the byte starts the next word
    if4.dout_ready = 1'b1;
    strobe4(8'h66);
    check("t3_xfer_valid", if4.dout_valid, 0);
    check("t3_xfer_cnt",   if4.byte_cnt,   1);
    check("t3_xfer_ovr",   if4.overrun,    0);
    strobe4(8'h77);
    strobe4(8'h88);
    strobe4(8'h99);
    check("t3_next_valid", if4.dout_valid, 1);
    check("t3_next_dout",  if4.dout,       32'h99887766);
    tick();
    check("t3_next_drop", if4.dout_valid, 0);

    // Flush mid-fill with a concurrent strobe
    for (int i = 0; i < 7; i++) strobe16(8'h10 + 8'(i));
    check("t4_cnt_7", if16.byte_cnt, 7);
    if16.flush   = 1'b1;
    if16.rx_done = 1'b1;
    if16.din     = 8'hEE;
    tick();
    if16.flush   = 1'b0;
    if16.rx_done = 1'b0;
    check("t4_flush_cnt",   if16.byte_cnt,   0);
    check("t4_flush_ovr",   if16.overrun,    0);
    check("t4_flush_valid", if16.dout_valid, 0);
    for (int i = 0; i < 16; i++) strobe16(8'h20 + 8'(i));
    check("t4_clean_valid", if16.dout_valid, 1);
    check("t4_clean_dout",  if16.dout, 128'h202122232425262728292A2B2C2D2E2F);
    tick();

    // Asynchronous reset mid-fill
    for (int i = 0; i < 5; i++) strobe16(8'hF0 + 8'(i));
    check("t4_cnt_5", if16.byte_cnt, 5);
    #2 reset = 1'b1;
    #1;
    check("t4_rst_cnt",   if16.byte_cnt,   0);
    check("t4_rst_dout",  if16.dout,       '0);
    check("t4_rst_valid", if16.dout_valid, 0);
    check("t4_rst_dout4", if4.dout,        '0);
    #2 reset = 1'b0;
    tick();

    // Back-to-back strobes for 32 cycles
    valid_seq = '0;
    ovr_seen  = 1'b0;
    word_a    = '0;
    word_b    = '0;
    if16.rx_done = 1'b1;
    for (int i = 0; i < 32; i++) begin
      if16.din = 8'h30 + 8'(i);
      tick();
      valid_seq[i] = if16.dout_valid;
      ovr_seen     = ovr_seen | if16.overrun;
      if (i == 15) word_a = if16.dout;
      if (i == 31) word_b = if16.dout;
    end
    if16.rx_done = 1'b0;
    check("t6_valid_seq", valid_seq, 32'h8000_8000);
    check("t6_no_overrun", ovr_seen, 0);
    check("t6_word_a", word_a, 128'h303132333435363738393A3B3C3D3E3F);
    check("t6_word_b", word_b, 128'h404142434445464748494A4B4C4D4E4F);
    tick();
    check("t6_idle", if16.dout_valid, 0);

    // Three bytes then silence
    strobe16(8'h01);
    strobe16(8'h02);
    strobe16(8'h03);
    to_seen = 1'b0;
    repeat (19) begin
      tick();
      to_seen = to_seen | if16.timeout;
    end
    check("t5_no_early_to", to_seen, 0);
    check("t5_cnt_19",      if16.byte_cnt, 3);
    tick();
    check("t5_timeout",     if16.timeout,    TO_EN);
    check("t5_to_cnt",      if16.byte_cnt,   TO_EN ? 0 : 3);
    check("t5_to_valid",    if16.dout_valid, 0);
    tick();
    check("t5_to_1cyc",     if16.timeout, 0);
    if16.flush = 1'b1;
    tick();
    if16.flush = 1'b0;

    // Strobe in the expiry cycle wins over the timeout
    strobe16(8'h01);
    strobe16(8'h02);
    strobe16(8'h03);
    repeat (19) tick();
    strobe16(8'h04);
    check("t5_edge_cnt", if16.byte_cnt, 4);
    check("t5_edge_to",  if16.timeout,  0);
    tick();
    check("t5_edge_to_after", if16.timeout, 0);
    if16.flush = 1'b1;
    tick();
    if16.flush = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
